// File: rtl/ulpi_reg_engine.sv
// ULPI immediate-address register engine behind the 8-bit register port.
// Handles PHY preemption retry, timeout and illegal-address errors.
module ulpi_reg_engine #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  EXT_ADDR       = 8'h2F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] reg_addr_i,
  input  logic       reg_stb_i,
  input  logic       reg_we_i,
  input  logic [7:0] reg_data_i,
  output logic [7:0] reg_data_o,
  output logic       reg_ack_o,
  output logic       reg_err_o,
  input  logic       utmi_busy_i,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_stp_o,
  output logic       ulpi_owner_o
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CMD   = 4'd1;
  localparam logic [3:0] WDATA = 4'd2;
  localparam logic [3:0] WSTP  = 4'd3;
  localparam logic [3:0] RTURN = 4'd4;
  localparam logic [3:0] RDATA = 4'd5;
  localparam logic [3:0] RWAIT = 4'd6;
  localparam logic [3:0] ABORT = 4'd7;
  localparam logic [3:0] TOUT  = 4'd8;
  localparam logic [3:0] ACK   = 4'd9;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       stp_q, stp_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       owner_q, owner_d;

  logic       active;
  logic       accept;
  logic       illegal;
  logic [7:0] cmd_byte;

  assign active   = (state_q != IDLE) && (state_q != ACK);
  assign accept   = reg_stb_i && !ulpi_dir_i && !utmi_busy_i;
  assign illegal  = (reg_addr_i[7:6] != 2'b00) || (reg_addr_i == EXT_ADDR);
  assign cmd_byte = {1'b1, ~we_q, addr_q[5:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wd_d    = wd_q;
    cnt_d   = active ? cnt_q + 8'd1 : cnt_q;
    data_d  = data_q;
    stp_d   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (active && state_q != TOUT && cnt_q == TO_LAST) begin
      // Timeout wins over any protocol progress
      state_d = TOUT;
      data_d  = 8'h00;
      stp_d   = ~ulpi_dir_i;
    end else begin
      case (state_q)
        IDLE: begin
          data_d = 8'h00;
          if (accept) begin
            addr_d = reg_addr_i;
            we_d   = reg_we_i;
            wd_d   = reg_data_i;
            cnt_d  = 8'h00;
            if (illegal) begin
              state_d = ACK;
              ack_d   = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = CMD;
              data_d  = {1'b1, ~reg_we_i, reg_addr_i[5:0]};
            end
          end
        end
        CMD: begin
          if (ulpi_dir_i) begin
            state_d = ABORT;
            data_d  = 8'h00;
          end else if (ulpi_nxt_i) begin
            state_d = we_q ? WDATA : RTURN;
            data_d  = we_q ? wd_q : 8'h00;
          end
        end
        WDATA: begin
          if (ulpi_dir_i) begin
            state_d = ABORT;
            data_d  = 8'h00;
          end else if (ulpi_nxt_i) begin
            state_d = WSTP;
            data_d  = 8'h00;
            stp_d   = 1'b1;
          end
        end
        WSTP: begin
          state_d = ACK;
          ack_d   = 1'b1;
        end
        RTURN: begin
          state_d = (ulpi_dir_i && ulpi_nxt_i) ? ABORT : RDATA;
        end
        RDATA: begin
          if (ulpi_dir_i && !ulpi_nxt_i) begin
            rdata_d = ulpi_data_i;
            state_d = RWAIT;
          end
        end
        RWAIT: begin
          if (!ulpi_dir_i) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end
        ABORT: begin
          data_d = 8'h00;
          if (!ulpi_dir_i) begin
            state_d = CMD;
            data_d  = cmd_byte;
          end
        end
        TOUT: begin
          state_d = ACK;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end
        ACK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          data_d  = 8'h00;
        end
      endcase
    end
    owner_d = (state_d != IDLE) && (state_d != ACK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      we_q    <= 1'b0;
      wd_q    <= 8'h00;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
      stp_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      stp_q   <= stp_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
    end
  end

  assign reg_data_o   = rdata_q;
  assign reg_ack_o    = ack_q;
  assign reg_err_o    = err_q;
  assign ulpi_data_o  = data_q;
  assign ulpi_stp_o   = stp_q;
  assign ulpi_owner_o = owner_q;

endmodule

// File: tb/tb_ulpi_reg_engine.sv
// Randomized bench for ulpi_reg_engine with a procedural PHY and
// a transaction-level model of expected bus bytes and results.
module tb_ulpi_reg_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       stb = 1'b0;
  logic       we = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata_o;
  logic       ack;
  logic       err;
  logic       busy = 1'b0;
  logic       dir = 1'b0;
  logic       nxt = 1'b0;
  logic [7:0] pdata = 8'h00;
  logic [7:0] udata;
  logic       stp;
  logic       owner;

  int checks = 0;
  int errors = 0;
  int pcnt = 0;
  logic [7:0] last_rd = 8'h00;

  ulpi_reg_engine dut (
    .clk_i(clk), .rst_i(rst),
    .reg_addr_i(addr), .reg_stb_i(stb), .reg_we_i(we),
    .reg_data_i(wdata), .reg_data_o(rdata_o),
    .reg_ack_o(ack), .reg_err_o(err),
    .utmi_busy_i(busy), .ulpi_dir_i(dir), .ulpi_nxt_i(nxt),
    .ulpi_data_i(pdata), .ulpi_data_o(udata),
    .ulpi_stp_o(stp), .ulpi_owner_o(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One request; gdir selects whether the hold-off uses dir or busy.
  task automatic do_req(input logic [7:0] a, input logic w,
                        input logic [7:0] wd, input logic [7:0] rd,
                        input int hold, input bit gdir,
                        input int pre, input int dly,
                        input int lat_exp);
    logic [7:0] cmd;
    bit         ill;
    int         t0;
    ill = (a >= 8'd64) || (a == 8'h2F);
    cmd = (w ? 8'h80 : 8'hC0) + (a % 64);
    addr = a; we = w; wdata = wd; stb = 1'b1;
    if (hold > 0) begin
      if (gdir) dir = 1'b1; else busy = 1'b1;
      repeat (hold) begin
        cyc();
        chk("hold_owner", owner, 0);
      end
      dir = 1'b0; busy = 1'b0;
    end
    t0 = pcnt;
    cyc();
    if (ill) begin
      chk("ill_owner", owner, 0);
      chk("ill_ack", ack, 1);
      chk("ill_err", err, 1);
      chk("ill_rdata", rdata_o, last_rd);
      stb = 1'b0;
      cyc();
      chk("ill_ack_once", ack, 0);
      return;
    end
    chk("cmd_byte", udata, cmd);
    chk("owner_on", owner, 1);
    if (pre > 0) begin
      dir = 1'b1;
      repeat (pre) begin
        cyc();
        chk("abort_data", udata, 0);
      end
      dir = 1'b0;
      cyc();
      chk("reissue", udata, cmd);
    end
    repeat (dly) begin
      cyc();
      chk("cmd_hold", udata, cmd);
    end
    nxt = 1'b1;
    cyc();
    if (w) begin
      chk("wdata", udata, wd);
      cyc();
      chk("stp", stp, 1);
      chk("stp_data", udata, 0);
      nxt = 1'b0;
      cyc();
    end else begin
      nxt = 1'b0;
      chk("turn_data", udata, 0);
      dir = 1'b1;
      cyc();
      pdata = rd;
      cyc();
      dir = 1'b0;
      pdata = 8'($urandom);
      cyc();
      last_rd = rd;
    end
    chk("ack", ack, 1);
    chk("err", err, 0);
    chk("owner_off", owner, 0);
    chk("rdata", rdata_o, last_rd);
    if (lat_exp > 0) chk("latency", pcnt - t0, lat_exp);
    stb = 1'b0;
    cyc();
    chk("ack_once", ack, 0);
  endtask

  task automatic do_timeout(input logic [7:0] a);
    int n;
    addr = a; we = 1'b0; stb = 1'b1;
    cyc();
    n = 0;
    while (!stp && n < 400) begin
      n++;
      cyc();
    end
    chk("tout_len", n, 255);
    chk("tout_stp", stp, 1);
    chk("tout_data", udata, 0);
    cyc();
    chk("tout_ack", ack, 1);
    chk("tout_err", err, 1);
    chk("tout_rdata", rdata_o, last_rd);
    stb = 1'b0;
    cyc();
  endtask

  initial begin
    logic [7:0] ra;
    bit         rw;
    bit         seen;
    repeat (2) cyc();
    chk("rst_owner", owner, 0);
    chk("rst_data", udata, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata_o, 0);
    rst = 1'b0;
    cyc();

    do_req(8'h04, 1'b1, 8'h45, 8'h00, 0, 1'b0, 0, 2, 0);
    do_req(8'h04, 1'b1, 8'h45, 8'h00, 0, 1'b0, 0, 0, 4);
    do_req(8'h00, 1'b0, 8'h00, 8'h24, 0, 1'b0, 0, 0, 5);
    do_req(8'h00, 1'b0, 8'h00, 8'h5A, 0, 1'b0, 6, 1, 0);
    do_timeout(8'h0A);
    do_req(8'h2F, 1'b1, 8'h11, 8'h00, 0, 1'b0, 0, 0, 0);
    do_req(8'h40, 1'b0, 8'h00, 8'h00, 0, 1'b0, 0, 0, 0);
    do_req(8'h16, 1'b1, 8'hA5, 8'h00, 3, 1'b0, 0, 0, 0);
    do_req(8'h15, 1'b0, 8'h00, 8'h3C, 2, 1'b1, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      if ($urandom_range(3) != 0) ra = ra % 64;
      rw = 1'($urandom);
      do_req(ra, rw, 8'($urandom), 8'($urandom),
             $urandom_range(2), 1'($urandom),
             ($urandom_range(3) == 0) ? $urandom_range(1, 4) : 0,
             $urandom_range(3), 0);
    end

    addr = 8'h04; we = 1'b1; wdata = 8'h77; stb = 1'b1;
    cyc();
    nxt = 1'b1;
    cyc();
    chk("pre_rst_wdata", udata, 8'h77);
    nxt = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_data", udata, 0);
    chk("mid_rst_stp", stp, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    last_rd = 8'h00;
    stb = 1'b0;
    cyc();
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      cyc();
      if (ack) seen = 1'b1;
    end
    chk("no_ack_after_rst", seen, 0);
    chk("idle_after_rst", owner, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
